// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Divisor constants assume a 100 MHz input clock.
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 25;
  localparam int DEFAULT_DIV   = 1000000;

  // Half-period = divisor + 1 input cycles
  localparam int DIV_50HZ = 999999;
  localparam int DIV_1KHZ = 49999;
  localparam int DIV_1HZ  = 49999999;

  typedef enum logic [1:0] {
    STEP_OFF,
    STEP_SYNC,
    STEP_TERM,
    STEP_COUNT
  } ch_step_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: up-counter, active/shadow divisor pair, registered
// divided clock, tick strobe and load-pending flag.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int RST_DIV = 1000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             div_clk_o,
  output logic             tick_o,
  output logic             load_pend_o
);

  ch_step_e         step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic [CNT_W-1:0] latest;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;

  // A load arriving on a restart cycle wins over the older shadow value
  assign latest = load_i ? div_i : shd_q;

  always_comb begin
    if (!en_i)                step = STEP_OFF;
    else if (sync_i)          step = STEP_SYNC;
    else if (cnt_q == act_q)  step = STEP_TERM;
    else                      step = STEP_COUNT;
  end

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    pend_d = pend_q;
    unique case (step)
      STEP_OFF, STEP_SYNC: begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        act_d  = latest;
        shd_d  = latest;
        pend_d = 1'b0;
      end
      STEP_TERM: begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = 1'b1;
        // A load landing on the terminal count waits for the next one
        if (load_i) begin
          shd_d  = div_i;
          pend_d = 1'b1;
        end else if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end
      STEP_COUNT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (load_i) begin
          shd_d  = div_i;
          pend_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      act_q  <= CNT_W'(RST_DIV);
      shd_q  <= CNT_W'(RST_DIV);
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign div_clk_o   = clk_q;
  assign tick_o      = tick_q;
  assign load_pend_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Define CLKDIV_SYNC_EN to add a sync input that restarts all enabled channels in phase.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic                    clk_in,
  input  logic                    rst,
`ifdef CLKDIV_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       load_pend
);

  logic sync_w;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in      (clk_in),
      .rst         (rst),
      .en_i        (ch_en[k]),
      .sync_i      (sync_w),
      .load_i      (div_load[k]),
      .div_i       (div_in[k*CNT_W +: CNT_W]),
      .div_clk_o   (div_clk[k]),
      .tick_o      (tick[k]),
      .load_pend_o (load_pend[k])
    );
  end

endmodule
